// File: rtl/farm_pkg.sv
// Shared definitions for the farm telemetry serial link (transmit side now,
// receiver later).
package farm_pkg;

  localparam logic [7:0]  FARM_SYNC_BYTE   = 8'hA5;
  localparam int unsigned FARM_FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } farm_tx_state_t;

  function automatic logic [7:0] farm_checksum(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return b0 ^ b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/farm_telemetry_tx_if.sv
// Payload/request bundle and line/status feedback for the telemetry transmitter.
interface farm_telemetry_tx_if;
  logic       ena;
  logic       start;
  logic [7:0] moisture;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic [7:0] status;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] byte_idx;

  modport master (
    output ena, start, moisture, temperature, humidity, status,
    input  tx, busy, done, byte_idx
  );

  modport slave (
    input  ena, start, moisture, temperature, humidity, status,
    output tx, busy, done, byte_idx
  );
endinterface

// File: rtl/farm_uart_byte_tx.sv
// 8N1 LSB-first byte serialiser. A load accepted at the end of a stop bit
// starts the next start bit with no idle gap.
module farm_uart_byte_tx
  import farm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  farm_tx_state_t state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == BIT_LAST);
    ready   = ena && ((state_q == IDLE) || ((state_q == STOP_BIT) && bit_end));

    // Counter is pinned at zero while idle so every byte starts phase-aligned.
    cnt_d = ((state_q == IDLE) || bit_end) ? '0 : cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START_BIT;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (load) begin
            state_d = START_BIT;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done_q is held while disabled so a pending pulse surfaces once ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = done_q && ena;

endmodule

// File: rtl/farm_telemetry_tx.sv
// Telemetry frame transmitter: captures a 4-byte payload on start and sends
// sync, payload and XOR checksum as six back-to-back UART bytes.
module farm_telemetry_tx
  import farm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic                clk,
  input  logic                rst_n,
  farm_telemetry_tx_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(FARM_FRAME_BYTES - 1);

  logic [7:0] moisture_q, temperature_q, humidity_q, status_q, checksum_q;
  logic [2:0] byte_idx_q;
  logic [2:0] next_idx;
  logic       eng_ready, eng_busy, eng_tx, eng_done, eng_load;
  logic [7:0] eng_data, next_byte;
  logic       accept, stop_end, last_byte;

  always_comb begin
    accept    = eng_ready && !eng_busy && bus.start;
    stop_end  = eng_ready && eng_busy;
    last_byte = (byte_idx_q == LAST_IDX);
    eng_load  = accept || (stop_end && !last_byte);
    next_idx  = byte_idx_q + 3'd1;

    unique case (next_idx)
      3'd1:    next_byte = moisture_q;
      3'd2:    next_byte = temperature_q;
      3'd3:    next_byte = humidity_q;
      3'd4:    next_byte = status_q;
      3'd5:    next_byte = checksum_q;
      default: next_byte = FARM_SYNC_BYTE;
    endcase

    eng_data = accept ? FARM_SYNC_BYTE : next_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moisture_q    <= '0;
      temperature_q <= '0;
      humidity_q    <= '0;
      status_q      <= '0;
      checksum_q    <= '0;
      byte_idx_q    <= '0;
    end else if (accept) begin
      moisture_q    <= bus.moisture;
      temperature_q <= bus.temperature;
      humidity_q    <= bus.humidity;
      status_q      <= bus.status;
      checksum_q    <= farm_checksum(bus.moisture, bus.temperature, bus.humidity, bus.status);
      byte_idx_q    <= '0;
    end else if (stop_end) begin
      byte_idx_q    <= last_byte ? '0 : next_idx;
    end
  end

  farm_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .load  (eng_load),
    .data  (eng_data),
    .ready (eng_ready),
    .tx    (eng_tx),
    .busy  (eng_busy),
    .done  (eng_done)
  );

  assign bus.tx       = eng_tx;
  assign bus.busy     = eng_busy;
  assign bus.done     = eng_done;
  assign bus.byte_idx = byte_idx_q;

endmodule

// File: doc/farm_telemetry_tx.md
Name: farm_telemetry_tx

Overview:
- Serialises one telemetry frame of sensor and actuator state onto a single UART line, 8N1, LSB first.
- Frame order: sync, moisture, temperature, humidity, status, checksum.
- Sits beside the precision-farming core as the transmit end of its serial link, feeding a host or a logging receiver.
- Captures a 4-byte payload on `start`, then shifts out 6 bytes autonomously.

Parameters:
- CLKS_PER_BIT, 87: clock cycles per UART bit. Legal range is 2..65535; the counter is 16 bits wide.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; when low, all state, counters and outputs freeze
- start  input  1  frame request, sampled on the rising edge of clk
- moisture  input  8  soil-moisture payload byte
- temperature  input  8  temperature payload byte
- humidity  input  8  humidity payload byte
- status  input  8  pump/valve/alarm flags payload byte
- tx  output  1  UART line, idle high
- busy  output  1  high while a frame is in flight
- done  output  1  one-cycle pulse when the last stop bit completes
- byte_idx  output  3  index of the byte currently on the line (0..5); 0 when idle

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx=1, busy=0, done=0, byte_idx=0, payload registers=0, counters=0. tx returns high immediately, including mid-frame.
- Start acceptance: start=1 with ena=1 in state IDLE latches all 4 payload bytes in that cycle (cycle 0).
- Checksum: computed at capture as moisture ^ temperature ^ humidity ^ status.
- Start while busy: ignored; no queueing.
- FSM states: IDLE, START_BIT, DATA, STOP_BIT.
  - IDLE -> START_BIT on an accepted start.
  - START_BIT -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP_BIT after 8 bits.
  - STOP_BIT -> START_BIT of the next byte after CLKS_PER_BIT cycles if byte_idx<5; otherwise STOP_BIT -> IDLE.
- Registered outputs: tx goes low in cycle 1. Each bit holds exactly CLKS_PER_BIT cycles.
- Data bit order: LSB first.
- Frame bytes:
  - byte 0 = 8'hA5 (sync)
  - byte 1 = moisture
  - byte 2 = temperature
  - byte 3 = humidity
  - byte 4 = status
  - byte 5 = checksum
- Byte spacing: no idle gap between bytes; the stop bit is followed directly by the next start bit.
- Frame length: 60*CLKS_PER_BIT cycles. busy=1 from cycle 1 through cycle 60*CLKS_PER_BIT inclusive.
- done: pulses in cycle 60*CLKS_PER_BIT+1, which is also the first IDLE cycle; busy=0 in that cycle.
- Back-to-back frames: a start asserted in the done cycle is accepted, so frames are gapless except for that single idle-high cycle.
- byte_idx: updates in the same cycle the start bit of each byte begins.
- ena=0: bit counter, bit index, byte index and state hold. tx holds its current level. done is forced 0 and any done due is delayed until ena returns. start is ignored.
- Payload inputs: may change freely after capture without affecting the frame in flight.
- Bit counter wrap: counts 0..CLKS_PER_BIT-1, then resets to 0 and advances the bit. It never free-runs in IDLE; it is held at 0.

Decomposition:
- Shared package farm_pkg holds:
  - localparam FARM_SYNC_BYTE = 8'hA5
  - localparam FARM_FRAME_BYTES = 6
  - the tx FSM state enum (2 bits)
  - a function farm_checksum(4 bytes) returning their XOR, shared with the future receiver
- Sub-module farm_uart_byte_tx owns:
  - the per-byte engine: start/data/stop sequencing, bit-period counter and shift register
  - handshake load/ready
- Frame sequencing, payload capture and the byte mux remain in the top block.

Test Plan:
- Reset during idle and mid-frame (at bit 3 of byte 2, CLKS_PER_BIT=4) -> tx=1, busy=0 and byte_idx=0 asynchronously, before the next clk edge. A fresh start afterwards gives a correct full frame.
- CLKS_PER_BIT=4, payload 0x12/0x34/0x56/0x78, start pulse -> the line decodes to bytes A5 12 34 56 78 08.
  - Each bit is 4 cycles.
  - busy is high for 240 cycles.
  - done pulses in cycle 241.
- Start re-asserted at cycles 10 and 100 of a frame -> ignored. The second frame begins only after done, and payload changes after capture do not alter the frame.
- Start held high continuously with payload 0xFF/0x00/0xAA/0x55 -> two frames A5 FF 00 AA 55 00 separated by exactly one idle-high cycle. done pulses once per frame.
- ena dropped for 17 cycles in the middle of byte 3 -> tx is frozen, the frame extends by exactly 17 cycles, and the decoded bytes are unchanged.
- CLKS_PER_BIT=2 boundary, checksum 0x00 case (payload 0x0F/0x0F/0xF0/0xF0) -> frame A5 0F 0F F0 F0 00, total 120 busy cycles, byte_idx steps 0..5.
